// File: rtl/display_mode_sequencer.sv
// Mode sequencer for the 4-digit display: live/history hex/decimal views,
// a circular snapshot history and an optional auto-cycle timer.
module display_mode_sequencer #(
    parameter int DEPTH       = 4,
    parameter int CYCLE_TICKS = 100_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_mode,
    input  logic                     btn_capture,
    input  logic                     btn_auto,
    input  logic [15:0]              live_hex,
    input  logic [15:0]              live_dec,
    output logic [15:0]              to_display,
    output logic [1:0]               mode,
    output logic [$clog2(DEPTH)-1:0] hist_idx,
    output logic [$clog2(DEPTH):0]   hist_count,
    output logic                     auto_on
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(CYCLE_TICKS);

    typedef enum logic [1:0] {
        LIVE_HEX = 2'd0,
        LIVE_DEC = 2'd1,
        HIST_HEX = 2'd2,
        HIST_DEC = 2'd3
    } mode_t;

    mode_t         mode_q, mode_d;
    logic [IW-1:0] hist_idx_q, hist_idx_d;
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] rd_addr_s;
    logic [CW-1:0] hist_count_q, hist_count_d;
    logic          auto_on_q, auto_on_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   rd_hex_s, rd_dec_s;
    logic [15:0]   buf_hex_q [DEPTH];
    logic [15:0]   buf_dec_q [DEPTH];
    logic          btn_mode_q, btn_capture_q, btn_auto_q;
    logic          ev_mode_s, ev_capture_s, ev_auto_s;
    logic          tick_s, step_s, wr_en_s;

    // Next-state computation: events, history pointers, mode step, timer, display word
    always_comb begin
        ev_mode_s    = btn_mode & ~btn_mode_q;
        ev_capture_s = btn_capture & ~btn_capture_q;
        ev_auto_s    = btn_auto & ~btn_auto_q;
        tick_s       = auto_on_q && (timer_q == TW'(CYCLE_TICKS - 1));
        step_s       = ev_mode_s | tick_s;
        wr_en_s      = ev_capture_s && ((mode_q == LIVE_HEX) || (mode_q == LIVE_DEC));

        mode_d       = mode_q;
        hist_idx_d   = hist_idx_q;
        wr_ptr_d     = wr_ptr_q;
        hist_count_d = hist_count_q;
        auto_on_d    = auto_on_q;
        timer_d      = timer_q;

        if (wr_en_s) begin
            wr_ptr_d   = wr_ptr_q + IW'(1);
            hist_idx_d = '0;
            if (hist_count_q != CW'(DEPTH)) begin
                hist_count_d = hist_count_q + CW'(1);
            end else begin
                hist_count_d = hist_count_q;
            end
        end else if (ev_capture_s) begin
            if (({1'b0, hist_idx_q} + CW'(1)) == hist_count_q) begin
                hist_idx_d = '0;
            end else begin
                hist_idx_d = hist_idx_q + IW'(1);
            end
        end else begin
            hist_idx_d = hist_idx_q;
        end

        // The step looks at the pre-capture count, so a capture in the same
        // cycle cannot open the history views.
        if (step_s) begin
            case (mode_q)
                LIVE_HEX: mode_d = LIVE_DEC;
                LIVE_DEC: begin
                    if (hist_count_q != CW'(0)) begin
                        mode_d     = HIST_HEX;
                        hist_idx_d = '0;
                    end else begin
                        mode_d = LIVE_HEX;
                    end
                end
                HIST_HEX: mode_d = HIST_DEC;
                HIST_DEC: mode_d = LIVE_HEX;
                default:  mode_d = LIVE_HEX;
            endcase
        end else begin
            mode_d = mode_q;
        end

        if (ev_auto_s) begin
            auto_on_d = ~auto_on_q;
            timer_d   = '0;
        end else if (!auto_on_q || step_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // A same-cycle write can land on the entry about to be shown.
        rd_addr_s = wr_ptr_d - IW'(1) - hist_idx_d;
        if (wr_en_s && (rd_addr_s == wr_ptr_q)) begin
            rd_hex_s = live_hex;
            rd_dec_s = live_dec;
        end else begin
            rd_hex_s = buf_hex_q[rd_addr_s];
            rd_dec_s = buf_dec_q[rd_addr_s];
        end

        case (mode_d)
            LIVE_HEX: disp_d = live_hex;
            LIVE_DEC: disp_d = live_dec;
            HIST_HEX: disp_d = rd_hex_s;
            HIST_DEC: disp_d = rd_dec_s;
            default:  disp_d = 16'h0000;
        endcase
    end

    // Sequencer state and registered display word
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q        <= LIVE_HEX;
            hist_idx_q    <= '0;
            wr_ptr_q      <= '0;
            hist_count_q  <= '0;
            auto_on_q     <= 1'b0;
            timer_q       <= '0;
            disp_q        <= 16'h0000;
            // Track the levels during reset so a held button is not an event.
            btn_mode_q    <= btn_mode;
            btn_capture_q <= btn_capture;
            btn_auto_q    <= btn_auto;
        end else begin
            mode_q        <= mode_d;
            hist_idx_q    <= hist_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            hist_count_q  <= hist_count_d;
            auto_on_q     <= auto_on_d;
            timer_q       <= timer_d;
            disp_q        <= disp_d;
            btn_mode_q    <= btn_mode;
            btn_capture_q <= btn_capture;
            btn_auto_q    <= btn_auto;
        end
    end

    // Snapshot history storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_hex_q[i] <= 16'h0000;
                buf_dec_q[i] <= 16'h0000;
            end
        end else if (wr_en_s) begin
            buf_hex_q[wr_ptr_q] <= live_hex;
            buf_dec_q[wr_ptr_q] <= live_dec;
        end
    end

    assign to_display = disp_q;
    assign mode       = mode_q;
    assign hist_idx   = hist_idx_q;
    assign hist_count = hist_count_q;
    assign auto_on    = auto_on_q;

endmodule
